// File: rtl/rx_drain_ctrl_pkg.sv
// rx_drain_ctrl_pkg
// Shared definitions for the receive-drain sequencer: FSM state encoding,
// frame-info field offsets, default parameters and a saturating increment.
// No ports.
package rx_drain_ctrl_pkg;

  // One-hot state encoding.
  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    INFO_RD  = 7'b0000010,
    INFO_LAT = 7'b0000100,
    BYTE_RD  = 7'b0001000,
    BYTE_LAT = 7'b0010000,
    OUT      = 7'b0100000,
    FLUSH    = 7'b1000000
  } stateT;

  // Frame-info word layout: [27:16] byte count, [15:4] ms stamp, [3:0] 0.1 ms stamp.
  localparam int INFO_W    = 28;
  localparam int LEN_MSB   = 27;
  localparam int LEN_LSB   = 16;
  localparam int STAMP_MSB = 15;

  localparam int          DEF_LEN_W       = 12;
  localparam logic [15:0] DEF_STALL_LIMIT = 16'd4096;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_drain_ctrl_if.sv
// rx_drain_ctrl_if
// Bundles the receive-FIFO side, frame-info FIFO side and the downstream
// byte stream of rx_drain_ctrl.
//   master : the drain sequencer (drives strobes and the output stream)
//   slave  : the environment (FIFOs, receive core, downstream consumer)
// Stream rule: a byte transfers on every rising clk edge where
// p_Valid_o & p_Ready_i; once raised, p_Valid_o and Data_o hold until that
// transfer (or until an abort withdraws the byte).
interface rx_drain_ctrl_if #(
  parameter int LEN_W = 12
);
  import rx_drain_ctrl_pkg::*;

  logic              p_Enable_i;
  logic              p_FrameMode_i;
  logic [7:0]        RxData_i;
  logic              p_RxEmpty_i;
  logic              p_RxOver_i;
  logic [INFO_W-1:0] RxFrameInfo_i;
  logic              p_RxFrameEmpty_i;
  logic              n_Rd_o;
  logic              n_RxFrameInfo_Rd_o;
  logic              n_Clr_o;
  logic [7:0]        Data_o;
  logic              p_Valid_o;
  logic              p_Ready_i;
  logic              p_Last_o;
  logic [LEN_W-1:0]  FrameLen_o;
  logic [15:0]       FrameStamp_o;
  logic              p_FrameDone_o;
  logic              p_Abort_o;
  logic [7:0]        AbortCnt_o;

  modport master (
    input  p_Enable_i, p_FrameMode_i, RxData_i, p_RxEmpty_i, p_RxOver_i,
           RxFrameInfo_i, p_RxFrameEmpty_i, p_Ready_i,
    output n_Rd_o, n_RxFrameInfo_Rd_o, n_Clr_o, Data_o, p_Valid_o, p_Last_o,
           FrameLen_o, FrameStamp_o, p_FrameDone_o, p_Abort_o, AbortCnt_o
  );

  modport slave (
    output p_Enable_i, p_FrameMode_i, RxData_i, p_RxEmpty_i, p_RxOver_i,
           RxFrameInfo_i, p_RxFrameEmpty_i, p_Ready_i,
    input  n_Rd_o, n_RxFrameInfo_Rd_o, n_Clr_o, Data_o, p_Valid_o, p_Last_o,
           FrameLen_o, FrameStamp_o, p_FrameDone_o, p_Abort_o, AbortCnt_o
  );

endinterface

// File: rtl/rx_stall_timer.sv
// rx_stall_timer
// 16-bit up-counter used to time how long a wait condition persists.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : return the count to zero (wins over en)
//   en       : count this cycle (saturates at 16'hFFFF)
//   limit    : cycle budget
//   hit      : high in the counting cycle that brings the count to limit
module rx_stall_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] limit,
  output logic        hit
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // Compare against the post-increment value so the caller can react in the
  // same cycle the limit-th waiting cycle occurs.
  assign hit = en && (({1'b0, count} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/rx_drain_ctrl.sv
// rx_drain_ctrl
// Empties the receive datapath. Frame mode: pop one frame-info word, then read
// exactly that many bytes and stream them with last-byte marking and the
// frame's length/timestamp sideband. Byte mode: stream each byte as it arrives.
// Overflow, a stalled frame or a mid-frame disable clears the byte FIFO and
// returns to IDLE; the frame-info FIFO is left alone so the next frame
// resynchronises from its own info word.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rx_drain_ctrl_if master (FIFO strobes/flags, byte stream, status)
//   dbgState : current FSM state
module rx_drain_ctrl
  import rx_drain_ctrl_pkg::*;
#(
  parameter logic [15:0] STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int          LEN_W       = DEF_LEN_W
) (
  input  logic           clk,
  input  logic           rst,
  rx_drain_ctrl_if.master bus,
  output stateT          dbgState
);

  stateT            state;
  logic             frameMode;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] infoLen;

  logic overReq;
  logic readOk;
  logic stallEn;
  logic stallHit;
  logic handshake;
  logic flushReq;

  assign infoLen   = bus.RxFrameInfo_i[LEN_LSB +: LEN_W];
  assign handshake = bus.p_Valid_o && bus.p_Ready_i;
  assign overReq   = bus.p_RxOver_i && (state != IDLE) && (state != FLUSH);
  assign readOk    = (state == BYTE_RD) && bus.p_Enable_i && !bus.p_RxEmpty_i && !overReq;
  assign stallEn   = (state == BYTE_RD) && bus.p_Enable_i && bus.p_RxEmpty_i && !overReq;

  // The byte strobe depends on the live empty flag: BYTE_RD holds while the
  // FIFO is empty, so the read cannot be decided a cycle early. Every other
  // strobe is registered.
  assign bus.n_Rd_o = !readOk;

  // Any condition that abandons the current frame through FLUSH. A disable in
  // byte mode needs no clear: nothing is half-delivered, so it just idles.
  assign flushReq = overReq
                 || stallHit
                 || ((state == BYTE_RD) && !bus.p_Enable_i && frameMode)
                 || ((state == OUT) && handshake && !bus.p_Last_o && !bus.p_Enable_i);

  rx_stall_timer u_stallTimer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!stallEn),
    .en    (stallEn),
    .limit (STALL_LIMIT),
    .hit   (stallHit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      frameMode              <= 1'b0;
      remaining              <= '0;
      bus.n_RxFrameInfo_Rd_o <= 1'b1;
      bus.n_Clr_o            <= 1'b1;
      bus.Data_o             <= '0;
      bus.p_Valid_o          <= 1'b0;
      bus.p_Last_o           <= 1'b0;
      bus.FrameLen_o         <= '0;
      bus.FrameStamp_o       <= '0;
      bus.p_FrameDone_o      <= 1'b0;
      bus.p_Abort_o          <= 1'b0;
      bus.AbortCnt_o         <= '0;
    end else begin
      bus.n_RxFrameInfo_Rd_o <= 1'b1;
      bus.n_Clr_o            <= 1'b1;
      bus.p_FrameDone_o      <= 1'b0;
      bus.p_Abort_o          <= 1'b0;

      if (flushReq) begin
        // Clear strobe and abort pulse line up with the single FLUSH cycle.
        state          <= FLUSH;
        bus.n_Clr_o    <= 1'b0;
        bus.p_Abort_o  <= 1'b1;
        bus.AbortCnt_o <= satInc8(bus.AbortCnt_o);
        bus.p_Valid_o  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.p_Enable_i) begin
              if (bus.p_FrameMode_i && !bus.p_RxFrameEmpty_i) begin
                frameMode              <= 1'b1;
                bus.n_RxFrameInfo_Rd_o <= 1'b0;
                state                  <= INFO_RD;
              end else if (!bus.p_FrameMode_i && !bus.p_RxEmpty_i) begin
                frameMode <= 1'b0;
                state     <= BYTE_RD;
              end
            end
          end

          INFO_RD: state <= INFO_LAT;

          INFO_LAT: begin
            bus.FrameLen_o   <= infoLen;
            bus.FrameStamp_o <= bus.RxFrameInfo_i[STAMP_MSB:0];
            remaining        <= infoLen;
            if (infoLen == '0) begin
              bus.p_FrameDone_o <= 1'b1;
              state             <= IDLE;
            end else begin
              state <= BYTE_RD;
            end
          end

          BYTE_RD: begin
            if (!bus.p_Enable_i) begin
              state <= IDLE;
            end else if (!bus.p_RxEmpty_i) begin
              state <= BYTE_LAT;
            end
          end

          BYTE_LAT: begin
            bus.Data_o    <= bus.RxData_i;
            bus.p_Valid_o <= 1'b1;
            bus.p_Last_o  <= !frameMode || (remaining == LEN_W'(1));
            state         <= OUT;
          end

          OUT: begin
            if (handshake) begin
              bus.p_Valid_o <= 1'b0;
              if (remaining != '0) begin
                remaining <= remaining - LEN_W'(1);
              end
              if (bus.p_Last_o) begin
                bus.p_FrameDone_o <= frameMode;
                state             <= IDLE;
              end else begin
                state <= BYTE_RD;
              end
            end
          end

          FLUSH: state <= IDLE;

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// tb_rx_drain_ctrl
// Directed bench for rx_drain_ctrl: FIFO models feed the design, expected
// {last, data} pairs go into exp_q, and a monitor pops and compares on every
// stream transfer.
module tb_rx_drain_ctrl;
  import rx_drain_ctrl_pkg::*;

  logic  clk;
  logic  rst;
  stateT dbgState;

  rx_drain_ctrl_if #(.LEN_W(12)) bus ();

  rx_drain_ctrl #(
    .STALL_LIMIT (16'd16),
    .LEN_W       (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [8:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [27:0] info_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt, info_cnt, clr_cnt, done_cnt, abort_cnt, stall_cycles;
  logic       prev_hold;
  logic [7:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    rd_cnt = 0; info_cnt = 0; clr_cnt = 0;
    done_cnt = 0; abort_cnt = 0; stall_cycles = 0;
  endtask

  task automatic push_frame(input logic [11:0] len, input logic [15:0] stamp,
                            input int nbytes, input logic [7:0] base, input bit expect_out);
    for (int i = 0; i < nbytes; i++) begin
      rx_q.push_back(base + 8'(i));
      if (expect_out)
        exp_q.push_back({(i == int'(len) - 1), base + 8'(i)});
    end
    info_q.push_back({len, stamp});
  endtask

  task automatic wait_drain(input string name, input int t_done, input int t_abort,
                            input int t_rd, input int budget);
    int n = 0;
    while (!(done_cnt >= t_done && abort_cnt >= t_abort && rd_cnt >= t_rd &&
             exp_q.size() == 0 && dbgState == IDLE) && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no completion after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_state(input string name, input stateT s, input int budget);
    int n = 0;
    while (dbgState != s && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: state 0x%0h never reached", name, s);
    end
  endtask

  // FIFO models: one-cycle read latency, flags updated at the clock edge.
  always @(posedge clk) begin
    if (!bus.n_Clr_o) rx_q.delete();
    if (!bus.n_Rd_o && rx_q.size() > 0) bus.RxData_i <= rx_q.pop_front();
    bus.p_RxEmpty_i <= (rx_q.size() == 0);
    if (!bus.n_RxFrameInfo_Rd_o && info_q.size() > 0) bus.RxFrameInfo_i <= info_q.pop_front();
    bus.p_RxFrameEmpty_i <= (info_q.size() == 0);
  end

  // monitor: pulse counting, hold-stability and stream scoreboard
  initial begin
    logic [8:0] e;
    prev_hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (!bus.n_Rd_o) rd_cnt++;
        if (!bus.n_RxFrameInfo_Rd_o) info_cnt++;
        if (!bus.n_Clr_o) clr_cnt++;
        if (bus.p_FrameDone_o) done_cnt++;
        if (bus.p_Abort_o) abort_cnt++;
        if (dbgState == BYTE_RD && bus.p_RxEmpty_i) stall_cycles++;
        if (prev_hold && bus.p_Valid_o)
          check("data_hold", 32'(bus.Data_o), 32'(hold_data));
        prev_hold = bus.p_Valid_o && !bus.p_Ready_i;
        hold_data = bus.Data_o;
        if (bus.p_Valid_o && bus.p_Ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got data 0x%0h last %0b, expected no transfer",
                     bus.Data_o, bus.p_Last_o);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", 32'({bus.p_Last_o, bus.Data_o}), 32'(e));
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int n;
    rst = 1'b1;
    bus.p_Enable_i    = 1'b1;
    bus.p_FrameMode_i = 1'b1;
    bus.p_RxOver_i    = 1'b0;
    bus.p_Ready_i     = 1'b1;
    clear_counts();
    repeat (3) tick();

    // reset state
    check("rst_n_rd", 32'(bus.n_Rd_o), 32'd1);
    check("rst_n_info_rd", 32'(bus.n_RxFrameInfo_Rd_o), 32'd1);
    check("rst_n_clr", 32'(bus.n_Clr_o), 32'd1);
    check("rst_valid", 32'(bus.p_Valid_o), 32'd0);
    check("rst_abort_cnt", 32'(bus.AbortCnt_o), 32'd0);
    check("rst_state", 32'(dbgState), 32'(IDLE));
    rst = 1'b0;
    tick();

    // 3-byte frame, stamp 0x1234
    clear_counts();
    push_frame(12'd3, 16'h1234, 3, 8'hA1, 1'b1);
    wait_drain("frame3", 1, 0, 3, 100);
    check("frame3_rd_pulses", 32'(rd_cnt), 32'd3);
    check("frame3_info_pulses", 32'(info_cnt), 32'd1);
    check("frame3_done", 32'(done_cnt), 32'd1);
    check("frame3_stamp", 32'(bus.FrameStamp_o), 32'h1234);
    check("frame3_len", 32'(bus.FrameLen_o), 32'd3);

    // zero-length frame
    clear_counts();
    push_frame(12'd0, 16'h0ABC, 0, 8'h00, 1'b1);
    wait_state("len0_start", INFO_RD, 20);
    n = 0;
    while (dbgState != IDLE && n < 20) begin
      n++;
      tick();
    end
    check("len0_busy_cycles", 32'(n), 32'd2);
    check("len0_done_pulse", 32'(bus.p_FrameDone_o), 32'd1);
    tick();
    check("len0_done_cnt", 32'(done_cnt), 32'd1);
    check("len0_rd_pulses", 32'(rd_cnt), 32'd0);
    check("len0_stamp", 32'(bus.FrameStamp_o), 32'h0ABC);

    // backpressure on byte 2
    clear_counts();
    push_frame(12'd3, 16'h0042, 3, 8'h11, 1'b1);
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin
      tick();
      n++;
    end
    bus.p_Ready_i = 1'b0;
    repeat (10) tick();
    check("bp_rd_pulses", 32'(rd_cnt), 32'd2);
    check("bp_valid", 32'(bus.p_Valid_o), 32'd1);
    check("bp_data", 32'(bus.Data_o), 32'h12);
    bus.p_Ready_i = 1'b1;
    wait_drain("bp", 1, 0, 3, 100);
    check("bp_done", 32'(done_cnt), 32'd1);

    // stalled frame: info says 4, only 2 bytes present
    clear_counts();
    push_frame(12'd4, 16'h0077, 2, 8'h60, 1'b1);
    wait_drain("stall", 0, 1, 2, 200);
    check("stall_cycles", 32'(stall_cycles), 32'd16);
    check("stall_clr_pulses", 32'(clr_cnt), 32'd1);
    check("stall_abort_pulses", 32'(abort_cnt), 32'd1);
    check("stall_abort_cnt", 32'(bus.AbortCnt_o), 32'd1);
    check("stall_done", 32'(done_cnt), 32'd0);
    check("stall_rd_pulses", 32'(rd_cnt), 32'd2);

    // overflow during BYTE_LAT
    clear_counts();
    push_frame(12'd3, 16'h0099, 3, 8'h80, 1'b0);
    wait_state("over", BYTE_LAT, 50);
    bus.p_RxOver_i = 1'b1;
    tick();
    bus.p_RxOver_i = 1'b0;
    check("over_state", 32'(dbgState), 32'(FLUSH));
    check("over_n_clr_low", 32'(bus.n_Clr_o), 32'd0);
    check("over_abort_pulse", 32'(bus.p_Abort_o), 32'd1);
    check("over_valid", 32'(bus.p_Valid_o), 32'd0);
    tick();
    check("over_n_clr_high", 32'(bus.n_Clr_o), 32'd1);
    check("over_idle", 32'(dbgState), 32'(IDLE));
    check("over_fifo_cleared", 32'(rx_q.size()), 32'd0);
    repeat (3) tick();
    check("over_done", 32'(done_cnt), 32'd0);
    check("over_abort_cnt", 32'(bus.AbortCnt_o), 32'd2);

    // byte mode, 5 bytes
    clear_counts();
    bus.p_FrameMode_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_q.push_back(8'hC0 + 8'(i));
      exp_q.push_back({1'b1, 8'hC0 + 8'(i)});
    end
    wait_drain("bytemode", 0, 0, 5, 100);
    check("byte_rd_pulses", 32'(rd_cnt), 32'd5);
    check("byte_info_pulses", 32'(info_cnt), 32'd0);
    check("byte_done", 32'(done_cnt), 32'd0);

    // reset asserted while a byte is held in OUT
    bus.p_Ready_i = 1'b0;
    rx_q.push_back(8'h5A);
    wait_state("rst_mid", OUT, 50);
    check("pre_rst_valid", 32'(bus.p_Valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.p_Valid_o), 32'd0);
    check("midrst_last", 32'(bus.p_Last_o), 32'd0);
    check("midrst_data", 32'(bus.Data_o), 32'd0);
    check("midrst_abort_cnt", 32'(bus.AbortCnt_o), 32'd0);
    check("midrst_len", 32'(bus.FrameLen_o), 32'd0);
    check("midrst_stamp", 32'(bus.FrameStamp_o), 32'd0);
    check("midrst_n_rd", 32'(bus.n_Rd_o), 32'd1);
    check("midrst_state", 32'(dbgState), 32'(IDLE));
    repeat (2) tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
